// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline.
//   XLEN             : architectural register / PC width
//   RESET_PC_DEFAULT : default PC loaded on reset
//   fetch_state_e    : fetch FSM states
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // S_REQ  : request not yet issued
    // S_WAIT : request accepted, response pending
    // S_DROP : response pending but stale (a redirect happened meanwhile)
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_slot.sv
// One-entry valid/ready holding register.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (clears valid and data)
//   load        : capture load_data and set valid
//   load_data   : payload to capture
//   consume     : downstream took the entry (valid && ready)
//   flush       : drop the entry; wins over load and consume
//   valid, data : current entry
module if_slot
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = 2 * XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             consume,
    input  logic             flush,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            // A load in the same cycle as a consume replaces the entry.
            valid <= 1'b1;
            data  <= load_data;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Holds the PC, issues one outstanding word read to
// instruction memory, and presents {pc, instr} to execute through a one-entry slot.
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   next_pc                        : from pc_mux (pc+4 or redirect target)
//   redirect                       : branch/jump/trap-return, one cycle
//   pc_out                         : PC register, to pc_mux
//   imem_req_valid/ready, imem_addr: request channel (word aligned)
//   imem_resp_valid, imem_rdata    : response channel
//   if_valid/ready, if_pc, if_instr: output slot to execute
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] next_pc,
    input  logic            redirect,
    output logic [XLEN-1:0] pc_out,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic            req_fire;
    logic            slot_load;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (req_fire) state_d = S_WAIT;
            end
            S_WAIT: begin
                // A response coinciding with a redirect still drains the request,
                // so go straight back to S_REQ; slot_load masks the data.
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                end else if (redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                // The stale response drains even if another redirect lands on it.
                if (imem_resp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    // Outputs. Only request when the slot is certain to be free by response time.
    always_comb begin
        imem_req_valid = rst_n && (state_q == S_REQ) && (!if_valid || if_ready) && !redirect;
        req_fire       = imem_req_valid && imem_req_ready;
        slot_load      = (state_q == S_WAIT) && imem_resp_valid && !redirect;
        imem_addr      = {pc_q[XLEN-1:2], 2'b00};
        pc_out         = pc_q;
    end

    // PC advances on a delivered fetch (mux supplies pc+4) or on a redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (redirect || slot_load) begin
            pc_q <= next_pc;
        end
    end

    logic [2*XLEN-1:0] slot_data;

    if_slot #(
        .WIDTH(2 * XLEN)
    ) u_if_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (slot_load),
        .load_data({pc_q, imem_rdata}),
        .consume  (if_valid && if_ready),
        .flush    (redirect),
        .valid    (if_valid),
        .data     (slot_data)
    );

    assign if_pc    = slot_data[2*XLEN-1:XLEN];
    assign if_instr = slot_data[XLEN-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small instruction-memory model and a
// pc_mux model (redirect target, else pc+4).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] pc_out;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    logic [31:0] redir_target;
    logic        stray_resp;
    int unsigned mem_lat;
    logic        pend;
    logic [31:0] paddr;
    int unsigned cnt;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .next_pc        (next_pc),
        .redirect       (redirect),
        .pc_out         (pc_out),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    // pc_mux model
    assign next_pc = redirect ? redir_target : pc_out + 32'd4;

    // Memory: response valid mem_lat cycles after acceptance; reset on rst_n.
    always @(posedge clk) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else begin
            if (pend) begin
                if (cnt == 1) pend <= 1'b0;
                else cnt <= cnt - 1;
            end
            if (imem_req_valid && imem_req_ready) begin
                pend  <= 1'b1;
                paddr <= imem_addr;
                cnt   <= mem_lat;
            end
        end
    end

    assign imem_resp_valid = (pend && cnt == 1) || stray_resp;
    assign imem_rdata      = mem_word(paddr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic skip(input int n);
        repeat (2 * n) tick();
    endtask

    // Leaves the bench in the first cycle after rst_n rises.
    task automatic do_reset();
        rst_n = 1'b0; redirect = 1'b0; redir_target = 32'h0; imem_req_ready = 1'b1;
        if_ready = 1'b1; stray_resp = 1'b0; mem_lat = 1;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect = 1'b0; redir_target = 32'h0; imem_req_ready = 1'b1;
        if_ready = 1'b1; stray_resp = 1'b0; mem_lat = 1;
        tick();
        tick();
        vecs++; if (pc_out !== 32'h0) begin $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'h0); errs++; end
        vecs++; if (if_valid !== 1'b0) begin $display("FAIL reset_if_valid got=%b exp=0", if_valid); errs++; end
        vecs++; if (if_pc !== 32'h0) begin $display("FAIL reset_if_pc got=%h exp=0", if_pc); errs++; end
        vecs++; if (if_instr !== 32'h0) begin $display("FAIL reset_if_instr got=%h exp=0", if_instr); errs++; end
        vecs++; if (imem_req_valid !== 1'b0) begin $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); errs++; end
        rst_n = 1'b1;
        #1;
        vecs++; if (imem_req_valid !== 1'b1) begin $display("FAIL first_req got=%b exp=1", imem_req_valid); errs++; end
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            a = 32'(4 * k);
            vecs++; if (imem_req_valid !== 1'b1) begin $display("FAIL zw_req_valid k=%0d got=%b exp=1", k, imem_req_valid); errs++; end
            vecs++; if (imem_addr !== a) begin $display("FAIL zw_addr got=%h exp=%h", imem_addr, a); errs++; end
            tick();
            vecs++; if (imem_req_valid !== 1'b0) begin $display("FAIL zw_wait_req got=%b exp=0", imem_req_valid); errs++; end
            tick();
            vecs++; if (if_valid !== 1'b1) begin $display("FAIL zw_if_valid k=%0d got=%b exp=1", k, if_valid); errs++; end
            vecs++; if (if_pc !== a) begin $display("FAIL zw_if_pc got=%h exp=%h", if_pc, a); errs++; end
            vecs++; if (if_instr !== mem_word(a)) begin $display("FAIL zw_if_instr got=%h exp=%h", if_instr, mem_word(a)); errs++; end
        end
    endtask

    task automatic test_req_stall();
        do_reset();
        skip(1);
        imem_req_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            vecs++; if (imem_req_valid !== 1'b1) begin $display("FAIL stall_req_valid i=%0d got=%b exp=1", i, imem_req_valid); errs++; end
            vecs++; if (imem_addr !== 32'h4) begin $display("FAIL stall_addr i=%0d got=%h exp=%h", i, imem_addr, 32'h4); errs++; end
            if (i > 0) begin
                vecs++; if (if_valid !== 1'b0) begin $display("FAIL stall_no_load i=%0d got=%b exp=0", i, if_valid); errs++; end
            end
            tick();
        end
        imem_req_ready = 1'b1;
        #1;
        tick();
        tick();
        vecs++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin
            $display("FAIL stall_slot got=%b/%h exp=1/%h", if_valid, if_pc, 32'h4); errs++; end
    endtask

    task automatic test_backpressure();
        do_reset();
        skip(3);
        if_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            vecs++; if (imem_req_valid !== 1'b0) begin $display("FAIL bp_req_valid i=%0d got=%b exp=0", i, imem_req_valid); errs++; end
            vecs++; if (if_valid !== 1'b1 || if_pc !== 32'h8) begin
                $display("FAIL bp_slot_hold i=%0d got=%b/%h exp=1/%h", i, if_valid, if_pc, 32'h8); errs++; end
            tick();
        end
        if_ready = 1'b1;
        #1;
        vecs++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hC) begin
            $display("FAIL bp_release_req got=%b/%h exp=1/%h", imem_req_valid, imem_addr, 32'hC); errs++; end
        tick();
        vecs++; if (if_valid !== 1'b0) begin $display("FAIL bp_consumed got=%b exp=0", if_valid); errs++; end
        tick();
        vecs++; if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== mem_word(32'hC)) begin
            $display("FAIL bp_next_slot got=%b/%h/%h exp=1/%h/%h", if_valid, if_pc, if_instr, 32'hC, mem_word(32'hC)); errs++; end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        skip(4);
        mem_lat = 3;
        #1;
        vecs++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h10) begin
            $display("FAIL rw_req got=%b/%h exp=1/%h", imem_req_valid, imem_addr, 32'h10); errs++; end
        tick();
        redirect = 1'b1; redir_target = 32'h100;
        #1;
        tick();
        redirect = 1'b0;
        #1;
        vecs++; if (pc_out !== 32'h100) begin $display("FAIL rw_pc got=%h exp=%h", pc_out, 32'h100); errs++; end
        for (int i = 0; i < 2; i++) begin
            vecs++; if (if_valid !== 1'b0) begin $display("FAIL rw_if_valid i=%0d got=%b exp=0", i, if_valid); errs++; end
            vecs++; if (imem_req_valid !== 1'b0) begin $display("FAIL rw_drop_req i=%0d got=%b exp=0", i, imem_req_valid); errs++; end
            tick();
        end
        vecs++; if (if_valid !== 1'b0) begin $display("FAIL rw_stale_load got=%b exp=0", if_valid); errs++; end
        vecs++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
            $display("FAIL rw_new_req got=%b/%h exp=1/%h", imem_req_valid, imem_addr, 32'h100); errs++; end
        mem_lat = 1;
        tick();
        tick();
        vecs++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== mem_word(32'h100)) begin
            $display("FAIL rw_slot got=%b/%h/%h exp=1/%h/%h", if_valid, if_pc, if_instr, 32'h100, mem_word(32'h100)); errs++; end
    endtask

    task automatic test_redirect_resp();
        do_reset();
        skip(2);
        tick();
        redirect = 1'b1; redir_target = 32'h200;
        #1;
        tick();
        redirect = 1'b0;
        #1;
        vecs++; if (if_valid !== 1'b0) begin $display("FAIL rr_no_load got=%b exp=0", if_valid); errs++; end
        vecs++; if (pc_out !== 32'h200) begin $display("FAIL rr_pc got=%h exp=%h", pc_out, 32'h200); errs++; end
        vecs++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin
            $display("FAIL rr_new_req got=%b/%h exp=1/%h", imem_req_valid, imem_addr, 32'h200); errs++; end
        tick();
        tick();
        vecs++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin
            $display("FAIL rr_slot got=%b/%h exp=1/%h", if_valid, if_pc, 32'h200); errs++; end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        skip(1);
        mem_lat = 3;
        tick();
        rst_n = 1'b0;
        #1;
        tick();
        vecs++; if (pc_out !== 32'h0) begin $display("FAIL rm_pc got=%h exp=0", pc_out); errs++; end
        vecs++; if (if_valid !== 1'b0 || if_instr !== 32'h0) begin
            $display("FAIL rm_slot got=%b/%h exp=0/0", if_valid, if_instr); errs++; end
        vecs++; if (imem_req_valid !== 1'b0) begin $display("FAIL rm_req_in_reset got=%b exp=0", imem_req_valid); errs++; end
        rst_n = 1'b1; imem_req_ready = 1'b0; stray_resp = 1'b1;
        #1;
        vecs++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            $display("FAIL rm_req got=%b/%h exp=1/0", imem_req_valid, imem_addr); errs++; end
        tick();
        stray_resp = 1'b0;
        #1;
        vecs++; if (if_valid !== 1'b0 || pc_out !== 32'h0 || imem_req_valid !== 1'b1) begin
            $display("FAIL rm_late_resp got=%b/%h/%b exp=0/0/1", if_valid, pc_out, imem_req_valid); errs++; end
        imem_req_ready = 1'b1; mem_lat = 1;
        #1;
        tick();
        tick();
        vecs++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem_word(32'h0)) begin
            $display("FAIL rm_refetch got=%b/%h/%h exp=1/0/%h", if_valid, if_pc, if_instr, mem_word(32'h0)); errs++; end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_req_stall();
        test_backpressure();
        test_redirect_wait();
        test_redirect_resp();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 3-stage RV32I pipeline. Holds the architectural PC register. Its `pc_out` feeds `pc_mux`, and it consumes the mux's `next_pc`. Issues word reads to instruction memory over a valid/ready request channel with variable-latency response, keeps at most one request outstanding, and delivers `{pc, instr}` to the execute stage through a one-entry output slot. Redirects (branch, jump, trap return) flush in-flight fetches and the slot.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.

Ports:
- `clk`, in, 1: clock. One clock domain.
- `rst_n`, in, 1: reset. Synchronous, active-low.
- `next_pc`, in, 32: from `pc_mux`.
- `redirect`, in, 1: `br_true | jump_en | epc_taken`, asserted by execute for one cycle.
- `pc_out`, out, 32: PC register, to `pc_mux`.
- `imem_req_valid`, out, 1: read request.
- `imem_req_ready`, in, 1: memory accepts request.
- `imem_addr`, out, 32: `{pc_out[31:2], 2'b00}`.
- `imem_resp_valid`, in, 1: read data valid. Arrives ≥1 cycle after acceptance.
- `imem_rdata`, in, 32: instruction word.
- `if_valid`, out, 1: output slot holds an instruction.
- `if_ready`, in, 1: execute accepts the slot.
- `if_pc`, out, 32: PC of the slot instruction.
- `if_instr`, out, 32: slot instruction.

## Operation
- FSM states:
  - `S_REQ`: request not yet issued.
  - `S_WAIT`: request accepted, response pending.
  - `S_DROP`: response pending but stale.
- `imem_req_valid = (state==S_REQ) && (!if_valid || if_ready) && !redirect`. A request is only issued when the slot is guaranteed free at response time.
- Transitions:
  - `S_REQ`: on `imem_req_valid && imem_req_ready` go to `S_WAIT`.
  - `S_WAIT`: on `imem_resp_valid`:
    - Load the slot with `if_valid<=1`, `if_pc<=pc_out`, `if_instr<=imem_rdata`.
    - Set `pc_out<=next_pc` (sequential +4 from mux).
    - Go to `S_REQ`.
  - `S_DROP`: on `imem_resp_valid`, discard data and go to `S_REQ`.
- Slot handshake: the slot clears when `if_valid && if_ready` and it is not reloaded in the same cycle.
- Redirect (highest priority, any state):
  - `pc_out<=next_pc` and `if_valid<=0`.
  - From `S_WAIT`, go to `S_DROP`.
  - From `S_REQ`, stay in `S_REQ`. The request is suppressed that cycle.
  - From `S_DROP`, stay in `S_DROP`.
- Simultaneous events:
  - Redirect together with `imem_resp_valid` in `S_WAIT`: the response is discarded and the FSM goes to `S_REQ`. No stale slot load occurs.
  - Redirect together with `if_ready`: the slot is consumed by execute that cycle. The flush still clears it, so there is no double issue.
- `imem_resp_valid` is ignored in `S_REQ`.
- Misaligned `next_pc[1:0]` is not checked here. Address bits [1:0] are forced to 0. Alignment faults are execute's concern.
- PC wraps modulo 2^32. This is inherited from the `pc_mux` adder and needs no special handling.

## Timing
- Reset (`rst_n==0` at a rising edge) takes priority over everything. Results:
  - `pc_out=RESET_PC`, `state=S_REQ`.
  - `if_valid=0`, `if_pc=0`, `if_instr=0`.
  - `imem_req_valid` is low while reset is asserted.
- Reset mid-fetch abandons the outstanding request. The memory is reset on the same `rst_n`.
- First request is issued in the cycle after `rst_n` rises.
- Latency: with zero-wait memory (ready=1, response 1 cycle after acceptance), the first instruction reaches the slot 2 cycles after the request cycle.
- Throughput: 1 instruction per 2 cycles. One outstanding request; a new request issues the cycle after the response.
- After a redirect, the next request uses the new PC. It issues the cycle after the redirect from `S_REQ`/`S_WAIT`-with-response, or the cycle after the stale response drains in `S_DROP`.
- `imem_req_valid`, once asserted, holds with a stable address until accepted unless a redirect occurs. A redirect may withdraw it.

## Structure
- `riscv_pkg` gains:
  - `fetch_state_e` (`S_REQ`, `S_WAIT`, `S_DROP`).
  - `RESET_PC_DEFAULT`.
  - `XLEN=32`.
- `pc_mux` stays external. It is instantiated beside `fetch_unit` at the top level.
- One sub-module: `if_slot`. It is the one-entry valid/ready holding register with load, consume and flush inputs, and is reused later for the EX/WB register.

## Test plan
- Reset and zero-wait memory, `if_ready=1`:
  - Requests at 0x0, 0x4, 0x8 every 2 cycles.
  - `if_pc`/`if_instr` match memory contents.
- `imem_req_ready` low for 3 cycles on request 0x4: `imem_addr` is held at 0x4 and `imem_req_valid` is held high; no slot change.
- `if_ready=0` with slot full at 0x8: no new request issues; slot holds 0x8 until ready, then a request for 0xC issues.
- Redirect to 0x100 while in `S_WAIT` for 0x10, response arriving 2 cycles later:
  - The 0x10 data is never presented.
  - The next request is 0x100.
  - `if_valid` is 0 from the cycle after the redirect.
- Redirect to 0x200 in the same cycle as the response: no slot load; next request 0x200.
- `rst_n` low mid-`S_WAIT`:
  - `pc_out=RESET_PC` and `if_valid=0`.
  - A late response in `S_REQ` is ignored.
